// File: rtl/dp_seq_pkg.sv
// Shared types and constants for the layer-level datapath sequencer.
package dp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_SHIFT,
        ST_COMPUTE,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [7:0] COM_CONV   = 8'h01;
    localparam logic [7:0] COM_DWCONV = 8'h02;
    localparam logic [7:0] COM_PWCONV = 8'h04;

    function automatic logic com_type_legal(input logic [7:0] t);
        return (t == COM_CONV) || (t == COM_DWCONV) || (t == COM_PWCONV);
    endfunction

endpackage

// File: rtl/dp_seq_watchdog.sv
// Clear/enable cycle counter; timeout is high once TIMEOUT-1 counted cycles have elapsed.
module dp_seq_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign timeout = (cnt == CW'(TIMEOUT - 1));

    // Holds at the terminal value so the flag stays asserted until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !timeout)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Layer controller: accepts one instruction, then per tile issues config, runs the
// vertical shift and waits for compute completion, with a watchdog on both waits.
module datapath_sequencer
    import dp_seq_pkg::*;
#(
    parameter int TILE_W  = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [7:0]        instr_com_type,
    input  logic [3:0]        instr_kernel_size,
    input  logic              instr_kn_size_mode,
    input  logic              instr_shift_mod,
    input  logic [TILE_W-1:0] instr_tile_num,
    output logic              config_enable,
    output logic [7:0]        com_type,
    output logic [3:0]        kernel_size,
    output logic              kn_size_mode,
    output logic              vertical_shift_mod,
    output logic              virtical_reg_shift,
    output logic              virreg_input_sel,
    input  logic              shift_done_from_virreg,
    input  logic              compute_done,
    output logic              busy,
    output logic [TILE_W-1:0] tile_idx,
    output logic              layer_done,
    output logic              error
);

    state_e            state, state_nxt;
    logic [TILE_W-1:0] tile_num;
    logic              last_tile;
    logic              wd_clr, wd_en, wd_timeout;
    logic              accept;

    assign accept    = (state == ST_IDLE) && instr_valid;
    assign last_tile = (tile_idx == tile_num - TILE_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wd_en     = (state == ST_SHIFT) || (state == ST_COMPUTE);
        case (state)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (!com_type_legal(instr_com_type))
                        state_nxt = ST_ERR;
                    else if (instr_tile_num == '0)
                        state_nxt = ST_DONE;
                    else
                        state_nxt = ST_CONFIG;
                end
            end
            ST_CONFIG: state_nxt = ST_SHIFT;
            // The done input is tested first so it wins over a same-cycle timeout.
            ST_SHIFT: begin
                if (shift_done_from_virreg)
                    state_nxt = ST_COMPUTE;
                else if (wd_timeout)
                    state_nxt = ST_ERR;
            end
            ST_COMPUTE: begin
                if (compute_done)
                    state_nxt = last_tile ? ST_DONE : ST_NEXT;
                else if (wd_timeout)
                    state_nxt = ST_ERR;
            end
            ST_NEXT:  state_nxt = ST_CONFIG;
            ST_DONE:  state_nxt = ST_IDLE;
            ST_ERR:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        wd_clr = (state_nxt != state);
    end

    dp_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (wd_en),
        .timeout (wd_timeout)
    );

    // Strobes are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_ready        <= 1'b1;
            busy               <= 1'b0;
            config_enable      <= 1'b0;
            virtical_reg_shift <= 1'b0;
            layer_done         <= 1'b0;
            error              <= 1'b0;
            com_type           <= '0;
            kernel_size        <= '0;
            kn_size_mode       <= 1'b0;
            vertical_shift_mod <= 1'b0;
            virreg_input_sel   <= 1'b0;
            tile_idx           <= '0;
            tile_num           <= '0;
        end else begin
            instr_ready        <= (state_nxt == ST_IDLE);
            busy               <= (state_nxt != ST_IDLE);
            config_enable      <= (state_nxt == ST_CONFIG);
            virtical_reg_shift <= (state_nxt == ST_SHIFT);
            layer_done         <= (state_nxt == ST_DONE);
            if (accept) begin
                com_type           <= instr_com_type;
                kernel_size        <= instr_kernel_size;
                kn_size_mode       <= instr_kn_size_mode;
                vertical_shift_mod <= instr_shift_mod;
                tile_num           <= instr_tile_num;
                tile_idx           <= '0;
                virreg_input_sel   <= 1'b0;
                error              <= 1'b0;
            end
            if (state_nxt == ST_ERR)
                error <= 1'b1;
            if (state_nxt == ST_NEXT) begin
                tile_idx         <= tile_idx + TILE_W'(1);
                virreg_input_sel <= ~virreg_input_sel;
            end
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized bench for datapath_sequencer with a cycle-count reference model of each layer.
module tb_datapath_sequencer;

    localparam int TILE_W = 16;
    localparam int TO     = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              instr_valid;
    logic              instr_ready;
    logic [7:0]        instr_com_type;
    logic [3:0]        instr_kernel_size;
    logic              instr_kn_size_mode;
    logic              instr_shift_mod;
    logic [TILE_W-1:0] instr_tile_num;
    logic              config_enable;
    logic [7:0]        com_type;
    logic [3:0]        kernel_size;
    logic              kn_size_mode;
    logic              vertical_shift_mod;
    logic              virtical_reg_shift;
    logic              virreg_input_sel;
    logic              shift_done_from_virreg;
    logic              compute_done;
    logic              busy;
    logic [TILE_W-1:0] tile_idx;
    logic              layer_done;
    logic              error;

    always #5 clk = ~clk;

    datapath_sequencer #(.TILE_W(TILE_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_com_type(instr_com_type), .instr_kernel_size(instr_kernel_size),
        .instr_kn_size_mode(instr_kn_size_mode), .instr_shift_mod(instr_shift_mod),
        .instr_tile_num(instr_tile_num), .config_enable(config_enable),
        .com_type(com_type), .kernel_size(kernel_size), .kn_size_mode(kn_size_mode),
        .vertical_shift_mod(vertical_shift_mod), .virtical_reg_shift(virtical_reg_shift),
        .virreg_input_sel(virreg_input_sel), .shift_done_from_virreg(shift_done_from_virreg),
        .compute_done(compute_done), .busy(busy), .tile_idx(tile_idx),
        .layer_done(layer_done), .error(error)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Per-tile datapath latencies: shift_done in the s-th SHIFT cycle, compute_done in the c-th COMPUTE cycle.
    int s_d[8];
    int c_d[8];
    bit spur;
    bit hold;

    int   obs_end, obs_kind, obs_ncfg, obs_ndone, obs_nshift, obs_nready;
    bit   obs_strobe_err, com_ok;
    logic obs_ready_after, obs_busy_after;
    int   obs_idx[$];
    int   obs_sel[$];

    // Expected cycle (counted from the accept edge) of layer_done/error, its kind, and config pulse count.
    task automatic model(input logic [7:0] ct, input int n,
                         output int e_end, output int e_kind, output int e_ncfg);
        int t;
        e_ncfg = 0;
        e_kind = 1;
        if (!(ct inside {8'h01, 8'h02, 8'h04})) begin
            e_end = 1; e_kind = 2; return;
        end
        t = 0;
        for (int i = 0; i < n; i++) begin
            e_ncfg++;
            t += 1;
            if (s_d[i] > TO) begin t += TO; e_kind = 2; break; end
            t += s_d[i];
            if (c_d[i] > TO) begin t += TO; e_kind = 2; break; end
            t += c_d[i];
            if (i < n - 1) t += 1;
        end
        e_end = t + 1;
    endtask

    // Issue one instruction at the current negedge and act as the datapath until the layer ends.
    task automatic run_layer(input logic [7:0] ct, input logic [3:0] ks, input logic km,
                             input logic sm, input int n);
        int sh_cnt, cp_cnt, tile;
        bit in_cmp;
        instr_com_type = ct; instr_kernel_size = ks; instr_kn_size_mode = km;
        instr_shift_mod = sm; instr_tile_num = TILE_W'(n); instr_valid = 1'b1;
        obs_end = 0; obs_kind = 0; obs_ncfg = 0; obs_ndone = 0; obs_nshift = 0; obs_nready = 0;
        obs_strobe_err = 0; com_ok = 1; obs_ready_after = 1'b0; obs_busy_after = 1'b1;
        obs_idx.delete(); obs_sel.delete();
        sh_cnt = 0; cp_cnt = 0; tile = 0; in_cmp = 0;
        @(posedge clk);
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            instr_valid = hold;
            shift_done_from_virreg = 1'b0;
            compute_done = 1'b0;
            if (layer_done) obs_ndone++;
            if (obs_end != 0) begin
                obs_ready_after = instr_ready;
                obs_busy_after  = busy;
                break;
            end
            if (instr_ready) obs_nready++;
            if (config_enable) begin
                obs_ncfg++;
                obs_idx.push_back(int'(tile_idx));
                obs_sel.push_back(int'(virreg_input_sel));
                if (com_type !== ct || kernel_size !== ks || kn_size_mode !== km ||
                    vertical_shift_mod !== sm) com_ok = 0;
                tile = obs_ncfg - 1;
                sh_cnt = 0;
            end
            if (layer_done) begin obs_end = k; obs_kind = 1; end
            if (error && obs_end == 0) begin
                obs_end = k; obs_kind = 2;
                if (config_enable || virtical_reg_shift || layer_done) obs_strobe_err = 1;
            end
            if (obs_end != 0) continue;
            if (virtical_reg_shift) begin
                obs_nshift++;
                sh_cnt++;
                if (sh_cnt == s_d[tile]) begin
                    shift_done_from_virreg = 1'b1; in_cmp = 1; cp_cnt = 0;
                end else if (spur && sh_cnt == 1) compute_done = 1'b1;
            end else if (in_cmp) begin
                cp_cnt++;
                if (cp_cnt == c_d[tile]) begin
                    compute_done = 1'b1; in_cmp = 0;
                end else if (spur && cp_cnt == 1) shift_done_from_virreg = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 0; shift_done_from_virreg = 0; compute_done = 0;
        instr_com_type = 0; instr_kernel_size = 0; instr_kn_size_mode = 0;
        instr_shift_mod = 0; instr_tile_num = 0; spur = 0; hold = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({instr_ready, config_enable, com_type, kernel_size, kn_size_mode, vertical_shift_mod,
             virtical_reg_shift, virreg_input_sel, busy, tile_idx, layer_done, error} !==
            {1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0})
            $display("FAIL reset_values: ready=%b busy=%b cfg=%b com=%h tile=%0d err=%b",
                     instr_ready, busy, config_enable, com_type, tile_idx, error);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_conv_layer();
        int e_end, e_kind, e_ncfg;
        for (int i = 0; i < 3; i++) begin s_d[i] = 4; c_d[i] = 10; end
        model(8'h01, 3, e_end, e_kind, e_ncfg);
        run_layer(8'h01, 4'h3, 1'b1, 1'b0, 3);
        n_chk++;
        if (obs_ncfg !== 3) $display("FAIL conv_cfg_count: got %0d want 3", obs_ncfg);
        else n_pass++;
        for (int i = 0; i < 3 && i < obs_ncfg; i++) begin
            n_chk++;
            if (obs_idx[i] !== i || obs_sel[i] !== i % 2)
                $display("FAIL conv_tile_sel[%0d]: got idx=%0d sel=%0d want idx=%0d sel=%0d",
                         i, obs_idx[i], obs_sel[i], i, i % 2);
            else n_pass++;
        end
        n_chk++;
        if (obs_ndone !== 1 || obs_kind !== 1 || obs_end !== e_end)
            $display("FAIL conv_done: got n=%0d kind=%0d at=%0d want n=1 kind=1 at=%0d",
                     obs_ndone, obs_kind, obs_end, e_end);
        else n_pass++;
        n_chk++;
        if (error !== 1'b0 || com_ok !== 1'b1)
            $display("FAIL conv_err_fields: got err=%b fields_ok=%0d want 0/1", error, com_ok);
        else n_pass++;
    endtask

    task automatic test_zero_tiles();
        run_layer(8'h02, 4'h5, 1'b0, 1'b1, 0);
        n_chk++;
        if (obs_end !== 1 || obs_kind !== 1 || obs_ncfg !== 0 || obs_nshift !== 0)
            $display("FAIL zero_tiles: got at=%0d kind=%0d cfg=%0d shift=%0d want 1/1/0/0",
                     obs_end, obs_kind, obs_ncfg, obs_nshift);
        else n_pass++;
        n_chk++;
        if (obs_ready_after !== 1'b1) $display("FAIL zero_tiles_ready: got %b want 1", obs_ready_after);
        else n_pass++;
    endtask

    task automatic test_illegal();
        int e_end, e_kind, e_ncfg;
        run_layer(8'h03, 4'h1, 1'b0, 1'b0, 2);
        n_chk++;
        if (obs_end !== 1 || obs_kind !== 2 || obs_ncfg !== 0 || obs_strobe_err !== 0)
            $display("FAIL illegal_type: got at=%0d kind=%0d cfg=%0d strobes=%0d want 1/2/0/0",
                     obs_end, obs_kind, obs_ncfg, obs_strobe_err);
        else n_pass++;
        n_chk++;
        if (error !== 1'b1 || obs_busy_after !== 1'b0)
            $display("FAIL illegal_sticky: got err=%b busy=%b want 1/0", error, obs_busy_after);
        else n_pass++;
        s_d[0] = 2; c_d[0] = 2;
        model(8'h04, 1, e_end, e_kind, e_ncfg);
        run_layer(8'h04, 4'h7, 1'b1, 1'b1, 1);
        n_chk++;
        if (error !== 1'b0 || obs_kind !== e_kind || obs_end !== e_end)
            $display("FAIL illegal_then_legal: got err=%b kind=%0d at=%0d want 0/%0d/%0d",
                     error, obs_kind, obs_end, e_kind, e_end);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int e_end, e_kind, e_ncfg;
        s_d[0] = 3; c_d[0] = 1000; s_d[1] = 3; c_d[1] = 3;
        model(8'h01, 2, e_end, e_kind, e_ncfg);
        run_layer(8'h01, 4'h3, 1'b0, 1'b0, 2);
        n_chk++;
        if (obs_kind !== 2 || obs_end !== e_end || obs_ncfg !== e_ncfg || obs_strobe_err !== 0)
            $display("FAIL compute_timeout: got kind=%0d at=%0d cfg=%0d strobes=%0d want 2/%0d/%0d/0",
                     obs_kind, obs_end, obs_ncfg, obs_strobe_err, e_end, e_ncfg);
        else n_pass++;
        n_chk++;
        if (error !== 1'b1 || obs_busy_after !== 1'b0 || obs_ready_after !== 1'b1)
            $display("FAIL timeout_idle: got err=%b busy=%b ready=%b want 1/0/1",
                     error, obs_busy_after, obs_ready_after);
        else n_pass++;
    endtask

    task automatic test_spurious();
        int e_end, e_kind, e_ncfg;
        spur = 1;
        s_d[0] = TO; c_d[0] = 5; s_d[1] = 6; c_d[1] = TO;
        model(8'h02, 2, e_end, e_kind, e_ncfg);
        run_layer(8'h02, 4'h9, 1'b1, 1'b0, 2);
        spur = 0;
        n_chk++;
        if (obs_kind !== 1 || obs_end !== e_end || obs_ncfg !== 2)
            $display("FAIL spurious_and_tie: got kind=%0d at=%0d cfg=%0d want 1/%0d/2",
                     obs_kind, obs_end, obs_ncfg, e_end);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int e_end, e_kind, e_ncfg;
        bit seen;
        instr_com_type = 8'h01; instr_kernel_size = 4'h3; instr_kn_size_mode = 1'b1;
        instr_shift_mod = 1'b1; instr_tile_num = 16'd2; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = virtical_reg_shift;
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (!seen || {instr_ready, config_enable, com_type, kernel_size, kn_size_mode,
                      vertical_shift_mod, virtical_reg_shift, virreg_input_sel, busy, tile_idx,
                      layer_done, error} !==
            {1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0})
            $display("FAIL mid_shift_reset: got seen=%0d ready=%b busy=%b shift=%b com=%h want 1/1/0/0/00",
                     seen, instr_ready, busy, virtical_reg_shift, com_type);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s_d[0] = 2; c_d[0] = 4; s_d[1] = 3; c_d[1] = 1;
        model(8'h04, 2, e_end, e_kind, e_ncfg);
        run_layer(8'h04, 4'h1, 1'b0, 1'b0, 2);
        n_chk++;
        if (obs_kind !== 1 || obs_end !== e_end || obs_ncfg !== 2)
            $display("FAIL after_reset_layer: got kind=%0d at=%0d cfg=%0d want 1/%0d/2",
                     obs_kind, obs_end, obs_ncfg, e_end);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int e_end, e_kind, e_ncfg;
        hold = 1;
        s_d[0] = 2; c_d[0] = 3; s_d[1] = 1; c_d[1] = 2;
        model(8'h01, 2, e_end, e_kind, e_ncfg);
        run_layer(8'h01, 4'h2, 1'b0, 1'b1, 2);
        hold = 0;
        n_chk++;
        if (obs_nready !== 0 || obs_ready_after !== 1'b1 || obs_end !== e_end)
            $display("FAIL hold_ready: got ready_cycles=%0d ready_after=%b at=%0d want 0/1/%0d",
                     obs_nready, obs_ready_after, obs_end, e_end);
        else n_pass++;
        s_d[0] = 3; c_d[0] = 2;
        model(8'h02, 1, e_end, e_kind, e_ncfg);
        run_layer(8'h02, 4'h6, 1'b1, 1'b0, 1);
        n_chk++;
        if (obs_kind !== 1 || obs_end !== e_end || com_ok !== 1)
            $display("FAIL second_accept: got kind=%0d at=%0d fields_ok=%0d want 1/%0d/1",
                     obs_kind, obs_end, com_ok, e_end);
        else n_pass++;
    endtask

    task automatic test_random();
        int e_end, e_kind, e_ncfg, n;
        logic [7:0] ct;
        logic [7:0] legal [3] = '{8'h01, 8'h02, 8'h04};
        for (int it = 0; it < 25; it++) begin
            ct = ($urandom_range(7, 0) == 0) ? 8'($urandom) : legal[$urandom_range(2, 0)];
            n = $urandom_range(5, 0);
            for (int i = 0; i < 8; i++) begin
                s_d[i] = ($urandom_range(9, 0) == 0) ? $urandom_range(18, 15) : $urandom_range(8, 1);
                c_d[i] = ($urandom_range(9, 0) == 0) ? $urandom_range(18, 15) : $urandom_range(12, 1);
            end
            spur = 1'($urandom_range(1, 0));
            model(ct, n, e_end, e_kind, e_ncfg);
            run_layer(ct, 4'($urandom), 1'($urandom), 1'($urandom), n);
            n_chk++;
            if (obs_end !== e_end || obs_kind !== e_kind || obs_ncfg !== e_ncfg ||
                obs_ready_after !== 1'b1 || obs_busy_after !== 1'b0)
                $display("FAIL random[%0d] ct=%h n=%0d: got at=%0d kind=%0d cfg=%0d rdy=%b busy=%b want %0d/%0d/%0d/1/0",
                         it, ct, n, obs_end, obs_kind, obs_ncfg, obs_ready_after, obs_busy_after,
                         e_end, e_kind, e_ncfg);
            else n_pass++;
            if (obs_ncfg > 0) begin
                n_chk++;
                if (obs_idx[obs_ncfg-1] !== obs_ncfg - 1 || obs_sel[obs_ncfg-1] !== (obs_ncfg - 1) % 2 || com_ok !== 1)
                    $display("FAIL random_idx[%0d]: got idx=%0d sel=%0d ok=%0d want idx=%0d sel=%0d ok=1",
                             it, obs_idx[obs_ncfg-1], obs_sel[obs_ncfg-1], com_ok,
                             obs_ncfg - 1, (obs_ncfg - 1) % 2);
                else n_pass++;
            end
        end
        spur = 0;
    endtask

    initial begin
        test_reset();
        test_conv_layer();
        test_zero_tiles();
        test_illegal();
        test_timeout();
        test_spurious();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
